uart_bus_bridge: RTL
====================

UART_BUS_BRIDGE -- requirements
Module: uart_bus_bridge

Interface
REQ-001 Parameter InterByteTimeout, default 1_000_000, is the maximum number of idle clock cycles allowed between bytes of one command frame.
REQ-002 Parameter RspTimeout, default 255, is the maximum number of cycles the block waits for a bus response.
REQ-003 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-004 clk_i  input  1  block clock, all logic on rising edge.
REQ-005 rst_i  input  1  asynchronous active-high reset.
REQ-006 rx_valid_i  input  1  received byte available from the UART receive path.
REQ-007 rx_data_i  input  8  received byte.
REQ-008 rx_ready_o  output  1  block accepts rx_data_i this cycle.
REQ-009 tx_valid_o  output  1  response byte offered to the UART transmit path.
REQ-010 tx_data_o  output  8  response byte.
REQ-011 tx_ready_i  input  1  transmit path accepts tx_data_o this cycle.
REQ-012 host_req_o  output  1  bus request strobe, one cycle per transaction.
REQ-013 host_addr_o  output  32  bus address.
REQ-014 host_we_o  output  1  1 = write, 0 = read.
REQ-015 host_be_o  output  4  byte enables, always 4'hF.
REQ-016 host_wdata_o  output  32  write data.
REQ-017 host_rvalid_i  input  1  bus response valid, for reads and writes.
REQ-018 host_rdata_i  input  32  read data, valid with host_rvalid_i.

Function
REQ-019 A byte SHALL be accepted only on a cycle where rx_valid_i and rx_ready_o are both 1.
REQ-020 rx_ready_o SHALL be 1 in states IDLE, ADDR and DATA, and 0 in all other states.
REQ-021 In IDLE, byte 0x52 ('R') SHALL select read, go to ADDR and clear the byte counter.
REQ-022 In IDLE, byte 0x57 ('W') SHALL select write, go to ADDR and clear the byte counter.
REQ-023 In IDLE, any other byte SHALL go to RESP with the one-byte response 0x3F ('?').
REQ-024 ADDR SHALL collect 4 bytes, least significant first, into host_addr_o.
REQ-025 After the 4th ADDR byte, a read SHALL go to BUS_REQ and a write SHALL go to DATA.
REQ-026 DATA SHALL collect 4 bytes, least significant first, into host_wdata_o, then go to BUS_REQ.
REQ-027 In BUS_REQ, host_req_o SHALL be 1 for exactly one cycle, then the block SHALL enter BUS_WAIT.
REQ-028 host_addr_o, host_we_o and host_wdata_o SHALL hold stable from BUS_REQ until the block leaves BUS_WAIT.
REQ-029 host_rvalid_i SHALL be sampled only in BUS_WAIT and ignored in every other state.
REQ-030 In BUS_WAIT, host_rvalid_i = 1 on a read SHALL latch host_rdata_i and go to RESP with a 4-byte response, rdata least significant byte first.
REQ-031 In BUS_WAIT, host_rvalid_i = 1 on a write SHALL go to RESP with the one-byte response 0x4B ('K').
REQ-032 A wait counter SHALL clear on entry to BUS_WAIT and increment each cycle in BUS_WAIT.
REQ-033 If the wait counter reaches RspTimeout with no host_rvalid_i, the block SHALL go to RESP with the one-byte response 0x45 ('E'), and a later host_rvalid_i SHALL be ignored.
REQ-034 A gap counter SHALL clear on every accepted byte and increment each cycle in ADDR or DATA.
REQ-035 If the gap counter reaches InterByteTimeout, the block SHALL return to IDLE with no response and discard the partial frame.
REQ-036 In RESP, tx_valid_o SHALL be 1 and tx_data_o SHALL be the current response byte.
REQ-037 tx_data_o SHALL stay stable while tx_valid_o = 1 and tx_ready_i = 0.
REQ-038 Each tx_valid_o & tx_ready_i cycle SHALL advance to the next response byte; after the last byte the block SHALL go to IDLE on the next cycle.
REQ-039 tx_valid_o SHALL be 0 in all states other than RESP.
REQ-040 Counter widths SHALL be $clog2 of the relevant timeout + 1, with no wrap-around before the limit is reached.

Reset
REQ-041 While rst_i = 1, asynchronously: state = IDLE; all counters = 0; host_addr_o = 0, host_wdata_o = 0, latched rdata = 0.
REQ-042 While rst_i = 1: host_req_o = 0, host_we_o = 0, host_be_o = 4'hF, tx_valid_o = 0, tx_data_o = 0, rx_ready_o = 0.
REQ-043 Reset asserted mid-frame or mid-transaction SHALL abandon the frame or transaction, and no response SHALL be sent after reset is released.

Verification
REQ-044 Bytes 52 10 00 00 80, with rvalid two cycles after host_req_o and rdata 0xDEADBEEF -> one host_req_o pulse with addr 0x80000010, we = 0; then tx bytes EF BE AD DE.
REQ-045 Bytes 57 04 00 00 80 78 56 34 12 -> host_req_o with addr 0x80000004, we = 1, wdata 0x12345678, be = F; after rvalid, tx byte 4B.
REQ-046 Byte 0x00 in IDLE -> tx byte 3F, no host_req_o.
REQ-047 Read with no rvalid -> tx byte 45 after RspTimeout cycles; an rvalid injected afterwards produces no extra tx byte.
REQ-048 52 10, then InterByteTimeout idle cycles, then a full read frame -> the first frame is dropped silently and only the second read executes; tx_ready_i held low for 10 cycles during RESP -> tx_data_o stable and no bytes lost.

Source files
------------

// File: rtl/uart_bus_bridge_if.sv
// uart_bus_bridge_if: UART byte streams and host bus of the bridge.
// master = bridge side, slave = UART/bus environment side.
interface uart_bus_bridge_if;
    logic        rx_valid_i;
    logic [7:0]  rx_data_i;
    logic        rx_ready_o;
    logic        tx_valid_o;
    logic [7:0]  tx_data_o;
    logic        tx_ready_i;
    logic        host_req_o;
    logic [31:0] host_addr_o;
    logic        host_we_o;
    logic [3:0]  host_be_o;
    logic [31:0] host_wdata_o;
    logic        host_rvalid_i;
    logic [31:0] host_rdata_i;

    modport master (
        input  rx_valid_i, rx_data_i, tx_ready_i, host_rvalid_i, host_rdata_i,
        output rx_ready_o, tx_valid_o, tx_data_o, host_req_o, host_addr_o, host_we_o,
               host_be_o, host_wdata_o
    );
    modport slave (
        output rx_valid_i, rx_data_i, tx_ready_i, host_rvalid_i, host_rdata_i,
        input  rx_ready_o, tx_valid_o, tx_data_o, host_req_o, host_addr_o, host_we_o,
               host_be_o, host_wdata_o
    );
endinterface

// File: rtl/uart_bus_bridge.sv
// uart_bus_bridge: parses R/W command frames from a UART byte stream into
// single host bus transactions and returns a response byte stream.
module uart_bus_bridge #(
    parameter int InterByteTimeout = 1_000_000,
    parameter int RspTimeout       = 255
) (
    input logic clk_i,
    input logic rst_i,
    uart_bus_bridge_if.master bus
);
    localparam logic [2:0] IDLE = 3'd0, ADDR = 3'd1, DATA = 3'd2, BUS_REQ = 3'd3,
                           BUS_WAIT = 3'd4, RESP = 3'd5;
    localparam int GW = $clog2(InterByteTimeout + 1);
    localparam int WW = $clog2(RspTimeout + 1);
    localparam logic [GW-1:0] GapLast = GW'(InterByteTimeout - 1);
    localparam logic [WW-1:0] WaitLast = WW'(RspTimeout - 1);

    logic [2:0]    state_q, state_d;
    logic          we_q, we_d, multi_q, multi_d;
    logic [31:0]   addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
    logic [7:0]    code_q, code_d;
    logic [1:0]    cnt_q, cnt_d, idx_q, idx_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [WW-1:0] wait_q, wait_d;
    logic          acc, hs;

    assign acc = bus.rx_valid_i & bus.rx_ready_o;
    assign hs  = bus.tx_valid_o & bus.tx_ready_i;

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        multi_d = multi_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        code_d  = code_q;
        cnt_d   = cnt_q;
        idx_d   = '0;
        gap_d   = '0;
        wait_d  = '0;
        case (state_q)
            IDLE: if (acc) begin
                cnt_d = '0;
                if (bus.rx_data_i == 8'h52 || bus.rx_data_i == 8'h57) begin
                    we_d    = bus.rx_data_i == 8'h57;
                    state_d = ADDR;
                end else begin
                    code_d  = 8'h3F;
                    multi_d = 1'b0;
                    state_d = RESP;
                end
            end
            ADDR, DATA: begin
                gap_d = gap_q + 1'b1;
                if (acc) begin
                    gap_d = '0;
                    cnt_d = cnt_q + 2'd1;
                    if (state_q == ADDR) addr_d = {bus.rx_data_i, addr_q[31:8]};
                    else wdata_d = {bus.rx_data_i, wdata_q[31:8]};
                    if (cnt_q == 2'd3) state_d = (state_q == ADDR && we_q) ? DATA : BUS_REQ;
                end else if (gap_q == GapLast) state_d = IDLE;
            end
            BUS_REQ: state_d = BUS_WAIT;
            BUS_WAIT: begin
                wait_d = wait_q + 1'b1;
                if (bus.host_rvalid_i) begin
                    rdata_d = we_q ? rdata_q : bus.host_rdata_i;
                    multi_d = ~we_q;
                    code_d  = 8'h4B;
                    state_d = RESP;
                end else if (wait_q == WaitLast) begin
                    multi_d = 1'b0;
                    code_d  = 8'h45;
                    state_d = RESP;
                end
            end
            RESP: begin
                idx_d = hs ? idx_q + 2'd1 : idx_q;
                if (hs && (!multi_q || idx_q == 2'd3)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            multi_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            code_q  <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            gap_q   <= '0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            multi_q <= multi_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            code_q  <= code_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            gap_q   <= gap_d;
            wait_q  <= wait_d;
        end
    end

    // rx_ready is gated by rst_i because IDLE is also the reset state
    assign bus.rx_ready_o   = ~rst_i & (state_q == IDLE || state_q == ADDR || state_q == DATA);
    assign bus.tx_valid_o   = state_q == RESP;
    assign bus.tx_data_o    = state_q != RESP ? 8'h00 :
                              multi_q ? 8'(rdata_q >> {idx_q, 3'b000}) : code_q;
    assign bus.host_req_o   = state_q == BUS_REQ;
    assign bus.host_addr_o  = addr_q;
    assign bus.host_we_o    = we_q;
    assign bus.host_be_o    = 4'hF;
    assign bus.host_wdata_o = wdata_q;
endmodule
